// File: rtl/mult_pkg.sv
// Shared types for the sequential signed multiplier.
package mult_pkg;

  localparam int unsigned STATE_COUNT = 5;
  localparam int unsigned STATE_W     = $clog2(STATE_COUNT);

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CALC = 3'd2,
    S_SIGN = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/mult_shift_stage.sv
// One shift-and-add iteration step: multiplicand left by 1, multiplier right by 1 (logical).
module mult_shift_stage #(
  parameter int unsigned N  = 8,
  parameter int unsigned W2 = 2 * N
) (
  input  logic          en_i,
  input  logic [W2-1:0] mcand_i,
  input  logic [N-1:0]  mplier_i,
  output logic [W2-1:0] mcand_c_o,
  output logic [N-1:0]  mplier_c_o
);

  always_comb begin
    mcand_c_o  = mcand_i;
    mplier_c_o = mplier_i;
    if (en_i) begin
      mcand_c_o  = {mcand_i[W2-2:0], 1'b0};
      mplier_c_o = {1'b0, mplier_i[N-1:1]};
    end
  end

endmodule

// File: rtl/mult_sequencer.sv
// Sequential signed shift-and-add multiplier (sign-magnitude, N iterations).
// Optional MULT_EARLY_TERM_EN: leave CALC once the remaining multiplier is zero.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int unsigned W2 = 2 * N;
  localparam int unsigned CW = $clog2(N + 1);

  state_e          state_q;
  logic [N-1:0]    a_q, b_q;
  logic [W2-1:0]   mcand_q, acc_q, prod_q;
  logic [N-1:0]    mplier_q;
  logic [CW-1:0]   cnt_q;
  logic            sign_q, busy_q, done_q;

  logic [W2-1:0]   mcand_d;
  logic [N-1:0]    mplier_d;
  logic [N-1:0]    a_mag_c, b_mag_c;
  logic            calc_last_c;

  // Magnitudes; -2^(N-1) maps to 2^(N-1) as an unsigned N-bit value.
  always_comb begin
    a_mag_c = a_q[N-1] ? N'(-a_q) : a_q;
    b_mag_c = b_q[N-1] ? N'(-b_q) : b_q;
  end

  mult_shift_stage #(.N(N), .W2(W2)) u_shift (
    .en_i       (state_q == S_CALC),
    .mcand_i    (mcand_q),
    .mplier_i   (mplier_q),
    .mcand_c_o  (mcand_d),
    .mplier_c_o (mplier_d)
  );

`ifdef MULT_EARLY_TERM_EN
  assign calc_last_c = (mplier_d == '0) || (cnt_q == CW'(N - 1));
`else
  assign calc_last_c = (cnt_q == CW'(N - 1));
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      prod_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          mcand_q  <= W2'(a_mag_c);
          mplier_q <= b_mag_c;
          acc_q    <= '0;
          cnt_q    <= '0;
          sign_q   <= a_q[N-1] ^ b_q[N-1];
          state_q  <= S_CALC;
        end
        S_CALC: begin
          if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
          end
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + CW'(1);
          if (calc_last_c) begin
            state_q <= S_SIGN;
          end
        end
        S_SIGN: begin
          // Negating a zero accumulator yields zero, so no negative zero.
          prod_q  <= sign_q ? W2'(-acc_q) : acc_q;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer; honours MULT_EARLY_TERM_EN for expected latency.
module tb_mult_sequencer;

  localparam int unsigned N  = 8;
  localparam int unsigned W2 = 2 * N;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  a     = '0;
  logic [N-1:0]  b     = '0;
  logic          busy;
  logic          done;
  logic [W2-1:0] product;

  mult_sequencer #(.N(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W2-1:0] prod;
    int unsigned   due;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [W2-1:0] hold = '0;
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic check(input string nm, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
  endtask

  function automatic int unsigned bitlen(input logic [N-1:0] v);
    int unsigned l = 0;
    for (int i = 0; i < N; i++) if (v[i]) l = i + 1;
    return l;
  endfunction

  // Reference: exact signed product and latency from the operand values.
  function automatic logic [W2-1:0] model_prod(input logic [N-1:0] av, input logic [N-1:0] bv);
    longint p;
    p = longint'($signed(av)) * longint'($signed(bv));
    return W2'(p);
  endfunction

  function automatic int unsigned model_lat(input logic [N-1:0] bv);
    int mag;
    mag = $signed(bv);
    if (mag < 0) mag = -mag;
`ifdef MULT_EARLY_TERM_EN
    return 2 + ((bitlen(N'(mag)) > 1) ? bitlen(N'(mag)) : 1);
`else
    return N + 2;
`endif
  endfunction

  // Monitor: pops on every done pulse, otherwise product must hold.
  always @(negedge clk) begin
    if (reset) begin
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("product", product, mon_e.prod);
          check("latency", cyc, mon_e.due);
          check("busy_in_done", busy, 1);
          hold = mon_e.prod;
        end
      end else begin
        check("product_hold", product, hold);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", 0, 1);
  endtask

  task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv, input bit push);
    exp_t e;
    wait_idle();
    a     = av;
    b     = bv;
    start = 1'b1;
    if (push) begin
      e.prod = model_prod(av, bv);
      e.due  = cyc + 1 + model_lat(bv);
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_product", product, 0);
    reset = 1'b1;

    issue(8'd3,   8'd5,   1);
    issue(-8'sd7, 8'd6,   1);
    issue(8'd127, 8'h80,  1);
    issue(8'h80,  8'h80,  1);
    issue(8'd0,   -8'sd5, 1);
    issue(8'd5,   8'd1,   1);
    issue(8'd5,   8'h80,  1);
    issue(8'd0,   8'd0,   1);

    // Start while busy must be ignored, not queued.
    issue(8'd2, 8'd2, 1);
    @(negedge clk);
    a = 8'd9; b = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Abort mid-CALC; no done expected for this operation.
    issue(8'd7, 8'd3, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_product", product, 0);
    hold = '0;
    @(negedge clk);
    reset = 1'b1;
    issue(8'd4, 8'd4, 1);

    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] ra, rb;
      ra = N'($urandom);
      rb = N'($urandom);
      if (i % 10 == 3) rb = 8'h80;
      if (i % 10 == 7) ra = 8'h00;
      issue(ra, rb, 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 SHALL have parameter N, default 8, operand width in bits (N >= 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a multiply; sampled only in IDLE.
REQ-005 SHALL have port a  input  N  signed two's-complement multiplicand.
REQ-006 SHALL have port b  input  N  signed two's-complement multiplier.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse when product is valid.
REQ-009 SHALL have port product  output  2N  signed two's-complement result, registered.

Function
REQ-010 SHALL use FSM states IDLE, LOAD, CALC, SIGN, DONE.
REQ-011 IDLE: start=1 at an edge SHALL capture a, b and move to LOAD; start=0 SHALL keep IDLE.
REQ-012 LOAD SHALL form the N-bit unsigned magnitudes |a| and |b|, clear the 2N-bit accumulator and iteration counter, record sign = a[N-1] XOR b[N-1], then go to CALC.
REQ-013 CALC SHALL, per edge: if multiplier LSB=1, add the shifted multiplicand to the accumulator; shift the multiplicand left 1 and the multiplier right 1 (logical); increment the counter.
REQ-014 CALC SHALL go to SIGN after exactly N iterations (macro absent).
REQ-015 SIGN SHALL load product with the accumulator, or its two's-complement negation when sign=1, then go to DONE.
REQ-016 DONE SHALL drive done=1 for exactly one cycle, then return to IDLE.
REQ-017 Latency SHALL be exactly N+2 edges from the start-capture edge to the edge that asserts done (macro absent).
REQ-018 product SHALL hold its value from DONE until the next SIGN state; it SHALL NOT change during LOAD or CALC.
REQ-019 Magnitude of -2^(N-1) SHALL be 2^(N-1) in N unsigned bits; the accumulator SHALL be 2N bits, so no overflow is possible.
REQ-020 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-021 A zero operand SHALL give product=0 with no negative zero, and latency SHALL be unchanged.

Reset
REQ-022 reset=0 at an edge SHALL force IDLE, busy=0, done=0, product=0, and clear the accumulator, counter and sign, overriding any other input.
REQ-023 reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after release SHALL start a fresh operation.

Configuration
REQ-024 Macro MULT_EARLY_TERM_EN SHALL, when defined, leave CALC for SIGN at the first iteration edge after which the shifted multiplier is zero, with a minimum of one iteration.
REQ-025 With MULT_EARLY_TERM_EN defined, latency SHALL be 2 + max(1, bit-length of |b|) edges; all results SHALL be identical to the macro-absent build.
REQ-026 Without MULT_EARLY_TERM_EN, latency SHALL be fixed at N+2 edges per REQ-017.

Structure
REQ-027 Package mult_pkg SHALL hold the state enum type and the state-count constant.
REQ-028 The iteration shift step SHALL be a sub-module, mult_shift_stage (N, 2N), that shifts the multiplicand left and the multiplier right by 1 under an enable, in the same style as the existing shifter stage.
REQ-029 The total implementation SHALL be mult_sequencer plus mult_shift_stage plus mult_pkg only.

Verification (N=8)
REQ-030 Bench SHALL cover: a=3, b=5, start -> done exactly 10 edges later, product=16'h000F.
REQ-031 Bench SHALL cover: a=-7, b=6 -> product=16'hFFD6 (-42); a=127, b=-128 -> product=16'hC080 (-16256).
REQ-032 Bench SHALL cover: a=-128, b=-128 -> product=16'h4000; a=0, b=-5 -> product=16'h0000.
REQ-033 Bench SHALL cover: a=2, b=2, start; on the 3rd busy cycle set start=1, a=9, b=9 -> product=16'h0004 and only one done pulse.
REQ-034 Bench SHALL cover: reset=0 during CALC -> busy=0, done=0 and product=0 on the next edge; a following 4x4 -> 16'h0010.
REQ-035 Bench SHALL cover, with MULT_EARLY_TERM_EN: a=5, b=1 -> done at edge 3, product=16'h0005; a=5, b=-128 -> done at edge 10, product=16'hFD80.
